// File: rtl/ecc_sed_pkg.sv
// Shared types and helpers for the single-error-detect (even parity) arbiter.
package ecc_sed_pkg;

  localparam int unsigned DATA_W_DEF = 12;
  localparam int unsigned PAR_MAX_W  = 64;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Even parity over a word zero-extended to PAR_MAX_W; extension bits do not change the XOR.
  function automatic logic parity_f(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ecc_sed_encoder.sv
// Combinational even-parity encoder: codeword = {parity, data}.
module ecc_sed_encoder
  import ecc_sed_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W:0]   codeword_c
);

  assign codeword_c = {parity_f(PAR_MAX_W'(data_i)), data_i};

endmodule

// File: rtl/ecc_sed_arbiter.sv
// Round-robin arbiter feeding one parity encoder into a single-entry output register.
// Optional ECC_SED_ARBITER_ERR_INJ_EN adds err_inj to flip the stored parity bit.
module ecc_sed_arbiter
  import ecc_sed_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  localparam int unsigned SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CW_W   = DATA_W + 1,
  localparam int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
`ifdef ECC_SED_ARBITER_ERR_INJ_EN
  input  logic                      err_inj,
`endif
  output logic                      enc_valid,
  input  logic                      enc_ready,
  output logic [CW_W-1:0]           enc_codeword,
  output logic [SRC_W-1:0]          enc_src,
  output logic [CNT_W-1:0]          word_cnt
);

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   last_grant_q, last_grant_d;
  logic [CW_W-1:0]    codeword_q, codeword_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               found_c;
  logic [SRC_W-1:0]   grant_idx_c;
  logic               can_accept_c;
  logic               accept_c;
  logic               inj_c;
  logic [DATA_W-1:0]  grant_data_c;
  logic [CW_W-1:0]    enc_cw_c;

`ifdef ECC_SED_ARBITER_ERR_INJ_EN
  assign inj_c = err_inj;
`else
  assign inj_c = 1'b0;
`endif

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    int unsigned idx;
    found_c     = 1'b0;
    grant_idx_c = '0;
    idx         = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_grant_q) + i) % NUM_REQ;
      if (!found_c && req_valid[SRC_W'(idx)]) begin
        found_c     = 1'b1;
        grant_idx_c = SRC_W'(idx);
      end
    end
  end

  assign can_accept_c = (state_q == EMPTY) || enc_ready;
  assign accept_c     = found_c && can_accept_c;
  assign req_ready    = accept_c ? (NUM_REQ'(1) << grant_idx_c) : '0;
  assign grant_data_c = req_data[DATA_W*int'(grant_idx_c) +: DATA_W];

  ecc_sed_encoder #(
    .DATA_W (DATA_W)
  ) u_encoder (
    .data_i     (grant_data_c),
    .codeword_c (enc_cw_c)
  );

  // Next-state and output-register update.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    codeword_d   = codeword_q;
    src_d        = src_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      EMPTY: begin
        if (accept_c) state_d = FULL;
      end
      FULL: begin
        if (enc_ready && !accept_c) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    if (accept_c) begin
      last_grant_d = grant_idx_c;
      codeword_d   = {enc_cw_c[CW_W-1] ^ inj_c, enc_cw_c[DATA_W-1:0]};
      src_d        = grant_idx_c;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      last_grant_q <= SRC_W'(NUM_REQ - 1);
      codeword_q   <= '0;
      src_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      codeword_q   <= codeword_d;
      src_q        <= src_d;
      cnt_q        <= cnt_d;
    end
  end

  assign enc_valid    = (state_q == FULL);
  assign enc_codeword = codeword_q;
  assign enc_src      = src_q;
  assign word_cnt     = cnt_q;

endmodule

// File: doc/ecc_sed_arbiter.md
ECC_SED_ARBITER -- requirements
Module: ecc_sed_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the encoder (2..8).
REQ-002 Parameter DATA_W, default 12: data word width; codeword width is DATA_W+1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester word-valid.
REQ-006 req_data  input  NUM_REQ*DATA_W  per-requester data words; slice i belongs to requester i.
REQ-007 req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 enc_valid  output  1  registered codeword valid.
REQ-009 enc_ready  input  1  downstream accept.
REQ-010 enc_codeword  output  DATA_W+1  {parity, data}.
REQ-011 enc_src  output  clog2(NUM_REQ)  index of the requester that sourced enc_codeword.
REQ-012 word_cnt  output  16  count of words accepted since reset, saturating.

Function
REQ-013 Parity is even: enc_codeword[DATA_W] = XOR of all data bits; enc_codeword[DATA_W-1:0] = data unchanged.
REQ-014 Round-robin: search starts at (last_grant+1) mod NUM_REQ and grants the first requester with req_valid high; last_grant updates only on acceptance.
REQ-015 Acceptance (req_valid[i] & req_ready[i]) occurs only when the output register is empty, or full and draining in the same cycle (enc_valid & enc_ready).
REQ-016 req_ready is combinational from req_valid, last_grant and output-register state; it is never asserted to a requester whose req_valid is low.
REQ-017 Latency: a word accepted at edge k appears on enc_valid/enc_codeword/enc_src after edge k, i.e. one cycle later.
REQ-018 FSM states: EMPTY (enc_valid=0) and FULL (enc_valid=1). EMPTY->FULL on acceptance. FULL->EMPTY on drain without acceptance. FULL->FULL on drain with acceptance (back-to-back) or on stall.
REQ-019 Stall: while enc_valid & !enc_ready, enc_codeword and enc_src hold stable and all req_ready are 0.
REQ-020 Simultaneous drain and accept: the new word replaces the old one without a bubble; sustained throughput is 1 word per cycle.
REQ-021 No requests: the FSM stays or falls to EMPTY and last_grant holds.
REQ-022 word_cnt increments by 1 per acceptance and saturates at 16'hFFFF.
REQ-023 Requesters hold req_valid/req_data stable until accepted; grants are recomputed every cycle and never locked.

Reset
REQ-024 Synchronous reset sets: FSM to EMPTY; enc_valid=0; enc_codeword=0; enc_src=0; word_cnt=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-025 Reset dominates a simultaneous acceptance; a word held in the output register is discarded.
REQ-026 The cycle after reset deasserts, req_ready follows REQ-014/015 normally.

Configuration
REQ-027 Macro ECC_SED_ARBITER_ERR_INJ_EN, when defined, adds input err_inj (1 bit): an acceptance with err_inj=1 inverts the stored parity bit, for downstream checker testing.
REQ-028 Without the macro, the err_inj port does not exist and parity is always correct.

Structure
REQ-029 A shared package ecc_sed_pkg holds DATA_W default, the FSM state typedef {EMPTY, FULL}, and a parity function.
REQ-030 Parity generation is one sub-module, ecc_sed_encoder (data in, codeword out, purely combinational), instanced once on the granted word; arbitration and the output register live in ecc_sed_arbiter.

Verification
REQ-031 Single word: req_valid=4'b0001, req_data[0]=12'h001 -> req_ready=4'b0001; next cycle enc_valid=1, enc_codeword=13'h1001, enc_src=0, word_cnt=1.
REQ-032 Parity boundary: word 12'hFFF -> enc_codeword=13'h0FFF; word 12'h003 -> 13'h0003; word 12'h800 -> 13'h1800.
REQ-033 Fairness: all four req_valid held high, enc_ready=1 -> grant order 0,1,2,3,0, one per cycle with no bubbles; enc_src follows the same order.
REQ-034 Back-pressure: enc_ready=0 for 5 cycles while FULL -> enc_codeword/enc_src stable, req_ready=0; on enc_ready=1, next word is accepted the same cycle.
REQ-035 Reset mid-stream: assert rst while FULL with a pending request -> next cycle enc_valid=0, word_cnt=0, and requester 0 wins over requester 3 when both request.
REQ-036 With ECC_SED_ARBITER_ERR_INJ_EN: data 12'h001 with err_inj=1 -> enc_codeword=13'h0001.
